box_stack_control: RTL and testbench

- Upstream and downstream neighbour of the banking stage.
- Spawns one collectible box at a pseudo-random X position and detects player overlap. On pickup it adds one box to the player's stack.
- Consumes the banking stage's box_dropped pulse to remove one box, and produces player_current_height for that stage.
- All state advances only on game_en ticks.

---
 rtl/box_stack_control_if.sv | 48 ++++
 rtl/box_stack_control.sv | 158 +++++++++++++++
 tb/tb_box_stack_control.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/box_stack_control_if.sv
// ----------------------------------------------------------------------------
// box_stack_control_if
//
// Bundles the game-side signals of box_stack_control.
//   game_en               slow tick enable; every state change needs it high
//   player_x_pos          player left edge
//   box_dropped           one-tick drop request from the banking stage
//   player_current_height registered player height, base plus carried boxes
//   stack_count           number of boxes carried
//   box_active            collectible box visible on the field
//   box_x_pos             box left edge, valid while box_active is high
//   box_collected         one-tick pulse on pickup
//
// The master modport drives the stimulus side. The slave modport is the
// box_stack_control end.
// ----------------------------------------------------------------------------
interface box_stack_control_if;
    logic       game_en;
    logic [9:0] player_x_pos;
    logic       box_dropped;
    logic [9:0] player_current_height;
    logic [3:0] stack_count;
    logic       box_active;
    logic [9:0] box_x_pos;
    logic       box_collected;

    modport master (
        output game_en,
        output player_x_pos,
        output box_dropped,
        input  player_current_height,
        input  stack_count,
        input  box_active,
        input  box_x_pos,
        input  box_collected
    );

    modport slave (
        input  game_en,
        input  player_x_pos,
        input  box_dropped,
        output player_current_height,
        output stack_count,
        output box_active,
        output box_x_pos,
        output box_collected
    );
endinterface

// File: rtl/box_stack_control.sv
module box_stack_control #(
  parameter logic [9:0] PLAYER_BASE_HEIGHT = 10'd30,
  parameter logic [9:0] BOX_HEIGHT         = 10'd10,
  parameter logic [3:0] MAX_BOXES          = 4'd5,
  parameter logic [9:0] PLAYER_WIDTH       = 10'd20,
  parameter logic [9:0] BOX_WIDTH          = 10'd20,
  parameter logic [9:0] SPAWN_X_MIN        = 10'd150,
  parameter logic [9:0] SPAWN_X_MAX        = 10'd600,
  parameter logic [7:0] RESPAWN_TICKS      = 8'd60,
  parameter logic [9:0] LFSR_SEED          = 10'h2A5,
  parameter logic [9:0] BOX_LIFETIME       = 10'd300
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       game_en,
  input  logic [9:0] player_x_pos,
  input  logic       box_dropped,
  output logic [9:0] player_current_height,
  output logic [3:0] stack_count,
  output logic       box_active,
  output logic [9:0] box_x_pos,
  output logic       box_collected
);

  typedef enum logic [1:0] {
    ST_RESPAWN,
    ST_SPAWN,
    ST_ACTIVE
  } state_t;

  state_t     state_q,  state_d;
  logic [7:0] cnt_q,    cnt_d;
  logic [9:0] lfsr_q,   lfsr_d;
  logic [3:0] stack_q,  stack_d;
  logic [9:0] height_q, height_d;
  logic       active_q, active_d;
  logic [9:0] box_x_q,  box_x_d;
  logic       coll_q,   coll_d;
`ifdef BOX_TIMEOUT_EN
  logic [9:0] life_q,   life_d;
`endif

  logic [10:0] box_right;
  logic [10:0] player_right;
  logic        overlap;
  logic        pickup;
  logic        drop;

  assign box_right    = {1'b0, box_x_q} + {1'b0, BOX_WIDTH};
  assign player_right = {1'b0, player_x_pos} + {1'b0, PLAYER_WIDTH};
  assign overlap      = ({1'b0, player_x_pos} < box_right) &&
                        (player_right > {1'b0, box_x_q});

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    lfsr_d   = lfsr_q;
    stack_d  = stack_q;
    height_d = height_q;
    active_d = active_q;
    box_x_d  = box_x_q;
    coll_d   = coll_q;
`ifdef BOX_TIMEOUT_EN
    life_d   = life_q;
`endif
    pickup   = 1'b0;
    drop     = 1'b0;

    if (game_en) begin
      lfsr_d = {lfsr_q[8:0], lfsr_q[9] ^ lfsr_q[6]};
      coll_d = 1'b0;

      case (state_q)
        ST_RESPAWN: begin
          if (cnt_q == 8'd0) begin
            state_d = ST_SPAWN;
          end else begin
            cnt_d = cnt_q - 8'd1;
          end
        end
        ST_SPAWN: begin
          if ((lfsr_q >= SPAWN_X_MIN) && (lfsr_q <= SPAWN_X_MAX)) begin
            box_x_d  = lfsr_q;
            active_d = 1'b1;
            state_d  = ST_ACTIVE;
`ifdef BOX_TIMEOUT_EN
            life_d   = '0;
`endif
          end
        end
        ST_ACTIVE: begin
          if (overlap && (stack_q < MAX_BOXES)) begin
            pickup   = 1'b1;
            coll_d   = 1'b1;
            active_d = 1'b0;
            cnt_d    = RESPAWN_TICKS;
            state_d  = ST_RESPAWN;
`ifdef BOX_TIMEOUT_EN
          end else if (life_q == (BOX_LIFETIME - 10'd1)) begin
            active_d = 1'b0;
            cnt_d    = RESPAWN_TICKS;
            state_d  = ST_RESPAWN;
          end else begin
            life_d = life_q + 10'd1;
`endif
          end
        end
        default: begin
          state_d = ST_RESPAWN;
          cnt_d   = RESPAWN_TICKS;
        end
      endcase

      drop = box_dropped && (stack_q != 4'd0);
      if (pickup && !drop) begin
        stack_d = stack_q + 4'd1;
      end else if (drop && !pickup) begin
        stack_d = stack_q - 4'd1;
      end
      height_d = PLAYER_BASE_HEIGHT + (10'(stack_d) * BOX_HEIGHT);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_RESPAWN;
      cnt_q    <= RESPAWN_TICKS;
      lfsr_q   <= LFSR_SEED;
      stack_q  <= '0;
      height_q <= PLAYER_BASE_HEIGHT;
      active_q <= 1'b0;
      box_x_q  <= '0;
      coll_q   <= 1'b0;
`ifdef BOX_TIMEOUT_EN
      life_q   <= '0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      lfsr_q   <= lfsr_d;
      stack_q  <= stack_d;
      height_q <= height_d;
      active_q <= active_d;
      box_x_q  <= box_x_d;
      coll_q   <= coll_d;
`ifdef BOX_TIMEOUT_EN
      life_q   <= life_d;
`endif
    end
  end

  assign player_current_height = height_q;
  assign stack_count           = stack_q;
  assign box_active            = active_q;
  assign box_x_pos             = box_x_q;
  assign box_collected         = coll_q;

endmodule

// File: tb/tb_box_stack_control.sv
module tb_box_stack_control;

  logic       clk;
  logic       rst;
  logic       game_en;
  logic [9:0] player_x_pos;
  logic       box_dropped;
  logic [9:0] player_current_height;
  logic [3:0] stack_count;
  logic       box_active;
  logic [9:0] box_x_pos;
  logic       box_collected;

  int         n_vec;
  int         n_err;
  int         ticks_since;
  logic [9:0] ref_lfsr;

  box_stack_control #(
    .BOX_LIFETIME(10'd10)
  ) dut (
    .clk                   (clk),
    .rst                   (rst),
    .game_en               (game_en),
    .player_x_pos          (player_x_pos),
    .box_dropped           (box_dropped),
    .player_current_height (player_current_height),
    .stack_count           (stack_count),
    .box_active            (box_active),
    .box_x_pos             (box_x_pos),
    .box_collected         (box_collected)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    game_en = 1'b1;
    @(posedge clk);
    #1;
    game_en = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    ticks_since++;
    ref_lfsr = {ref_lfsr[8:0], ref_lfsr[9] ^ ref_lfsr[6]};
  endtask

  task automatic wait_spawn(input string tag);
    logic [9:0] cand;
    bit early;
    bit hit;
    early = 1'b0;
    hit   = 1'b0;
    cand  = '0;
    for (int unsigned i = 0; i < 400 && !hit; i++) begin
      cand = ref_lfsr;
      tick();
      if (ticks_since >= 62 && cand >= 10'd150 && cand <= 10'd600) hit = 1'b1;
      else if (box_active) early = 1'b1;
    end
    chk({tag, "_bound"}, 16'(hit), 16'd1);
    chk({tag, "_early"}, 16'(early), 16'd0);
    chk({tag, "_active"}, 16'(box_active), 16'd1);
    chk({tag, "_x"}, 16'(box_x_pos), 16'(cand));
    chk({tag, "_in_range"},
        16'((box_x_pos >= 10'd150) && (box_x_pos <= 10'd600)), 16'd1);
  endtask

  task automatic do_pickup(input int exp_cnt);
    player_x_pos = box_x_pos - 10'd10;
    tick();
    ticks_since = 0;
    chk("pick_pulse", 16'(box_collected), 16'd1);
    chk("pick_count", 16'(stack_count), 16'(exp_cnt));
    chk("pick_height", 16'(player_current_height), 16'(30 + 10 * exp_cnt));
    chk("pick_inactive", 16'(box_active), 16'd0);
    player_x_pos = 10'd0;
    tick();
    chk("pulse_one_tick", 16'(box_collected), 16'd0);
  endtask

  task automatic drop_step(input string tag, input int exp_cnt);
    box_dropped = 1'b1;
    tick();
    box_dropped = 1'b0;
    chk({tag, "_count"}, 16'(stack_count), 16'(exp_cnt));
    chk({tag, "_height"}, 16'(player_current_height), 16'(30 + 10 * exp_cnt));
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_height"}, 16'(player_current_height), 16'd30);
    chk({tag, "_count"}, 16'(stack_count), 16'd0);
    chk({tag, "_active"}, 16'(box_active), 16'd0);
    chk({tag, "_x"}, 16'(box_x_pos), 16'd0);
    chk({tag, "_pulse"}, 16'(box_collected), 16'd0);
  endtask

  initial begin
    n_vec        = 0;
    n_err        = 0;
    ticks_since  = 0;
    ref_lfsr     = 10'h2A5;
    rst          = 1'b0;
    game_en      = 1'b0;
    player_x_pos = 10'd0;
    box_dropped  = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    rst = 1'b1;

    wait_spawn("spawn0");
    chk("spawn0_height", 16'(player_current_height), 16'd30);

    player_x_pos = box_x_pos + 10'd20;
    tick();
    chk("edge_right_active", 16'(box_active), 16'd1);
    chk("edge_right_pulse", 16'(box_collected), 16'd0);
    player_x_pos = box_x_pos - 10'd20;
    tick();
    chk("edge_left_active", 16'(box_active), 16'd1);
    chk("edge_left_count", 16'(stack_count), 16'd0);

    do_pickup(1);
    for (int unsigned k = 2; k <= 5; k++) begin
      wait_spawn("respawn");
      do_pickup(int'(k));
    end

    wait_spawn("spawn_full");
    player_x_pos = box_x_pos - 10'd10;
    tick();
    chk("full_pulse", 16'(box_collected), 16'd0);
    chk("full_count", 16'(stack_count), 16'd5);
    chk("full_height", 16'(player_current_height), 16'd80);
    chk("full_active", 16'(box_active), 16'd1);
    tick();
    chk("full_active2", 16'(box_active), 16'd1);
    player_x_pos = 10'd0;
    tick();

    drop_step("drop5", 4);
    drop_step("drop4", 3);

    player_x_pos = box_x_pos - 10'd10;
    box_dropped  = 1'b1;
    tick();
    ticks_since  = 0;
    box_dropped  = 1'b0;
    player_x_pos = 10'd0;
    chk("both_pulse", 16'(box_collected), 16'd1);
    chk("both_count", 16'(stack_count), 16'd3);
    chk("both_height", 16'(player_current_height), 16'd60);
    chk("both_inactive", 16'(box_active), 16'd0);

    drop_step("drop3", 2);
    drop_step("drop2", 1);
    drop_step("drop1", 0);
    drop_step("drop_empty", 0);

    wait_spawn("spawn_life");
    repeat (9) tick();
    chk("life9_active", 16'(box_active), 16'd1);
    tick();
`ifdef BOX_TIMEOUT_EN
    ticks_since = 0;
    chk("timeout_inactive", 16'(box_active), 16'd0);
    chk("timeout_no_pulse", 16'(box_collected), 16'd0);
    chk("timeout_count", 16'(stack_count), 16'd0);
    wait_spawn("respawn_timeout");
`else
    chk("no_timeout_active", 16'(box_active), 16'd1);
    repeat (5) tick();
    chk("no_timeout_active2", 16'(box_active), 16'd1);
`endif

    do_pickup(1);
    wait_spawn("spawn_prereset");
    #4;
    rst = 1'b0;
    #1;
    chk_reset_outputs("async_rst");
    #5;
    rst = 1'b1;
    @(posedge clk);
    #1;
    ticks_since = 0;
    ref_lfsr    = 10'h2A5;
    wait_spawn("spawn_after_rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
